// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for pipelined_risc_v.
// Owns the PC, applies redirect/flush/stall, and latches a sticky fault on bad fetch addresses.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_pc_plus4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic             fetch_fault_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // 33 bits so a very large memory cannot wrap the limit to zero
    localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) << 2;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        if_id_pc_q, if_id_pc_d;
    logic [31:0]        if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0]        if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    function automatic logic target_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || addr_out_of_range(addr);
    endfunction

    // Next-state and next-output selection for the fetch FSM
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_valid_d    = if_id_valid_q;
        fault_d          = fault_q;
        count_d          = count_q;

        case (state_q)
            ST_BOOT: begin
                if_id_pc_d       = 32'h0000_0000;
                if_id_pc_plus4_d = 32'h0000_0000;
                if_id_instr_d    = NOP_INSTR;
                if_id_valid_d    = 1'b0;
                state_d          = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    if_id_pc_d       = 32'h0000_0000;
                    if_id_pc_plus4_d = 32'h0000_0000;
                    if_id_instr_d    = NOP_INSTR;
                    if_id_valid_d    = 1'b0;
                    pc_d             = redirect_target_i;
                    if (target_bad(redirect_target_i)) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (flush_i || !stall_i) begin
                    if (addr_out_of_range(pc_q)) begin
                        if_id_pc_d       = 32'h0000_0000;
                        if_id_pc_plus4_d = 32'h0000_0000;
                        if_id_instr_d    = NOP_INSTR;
                        if_id_valid_d    = 1'b0;
                        fault_d          = 1'b1;
                        state_d          = ST_FAULT;
                    end else if (flush_i) begin
                        if_id_pc_d       = 32'h0000_0000;
                        if_id_pc_plus4_d = 32'h0000_0000;
                        if_id_instr_d    = NOP_INSTR;
                        if_id_valid_d    = 1'b0;
                        pc_d             = stall_i ? pc_q : (pc_q + 32'd4);
                    end else begin
                        if_id_pc_d       = pc_q;
                        if_id_pc_plus4_d = pc_q + 32'd4;
                        if_id_instr_d    = imem_rdata_i;
                        if_id_valid_d    = 1'b1;
                        pc_d             = pc_q + 32'd4;
                        count_d          = count_q + CNT_W'(1);
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FAULT: begin
                if_id_pc_d       = 32'h0000_0000;
                if_id_pc_plus4_d = 32'h0000_0000;
                if_id_instr_d    = NOP_INSTR;
                if_id_valid_d    = 1'b0;
                fault_d          = 1'b1;
            end
            default: begin
                // An illegal encoding is treated as a fault so the pipeline cannot run on corrupt state
                if_id_pc_d       = 32'h0000_0000;
                if_id_pc_plus4_d = 32'h0000_0000;
                if_id_instr_d    = NOP_INSTR;
                if_id_valid_d    = 1'b0;
                fault_d          = 1'b1;
                state_d          = ST_FAULT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_PC;
            if_id_pc_q       <= 32'h0000_0000;
            if_id_pc_plus4_q <= 32'h0000_0000;
            if_id_instr_q    <= NOP_INSTR;
            if_id_valid_q    <= 1'b0;
            fault_q          <= 1'b0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            fault_q          <= fault_d;
            count_q          <= count_d;
        end
    end

    assign imem_addr_o      = pc_q;
    assign if_id_pc_o       = if_id_pc_q;
    assign if_id_pc_plus4_o = if_id_pc_plus4_q;
    assign if_id_instr_o    = if_id_instr_q;
    assign if_id_valid_o    = if_id_valid_q;
    assign fetch_fault_o    = fault_q;
    assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for fetch_if_id_stage: a 256-word instance for most scenarios
// and a 4-word instance for the end-of-memory fault.
module tb_fetch_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rst4  = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;

    logic [31:0] imem_addr, rdata, if_pc, if_pc4, if_instr, cnt;
    logic        if_valid, fault;
    logic [31:0] imem_addr4, rdata4, if_pc_4, if_pc4_4, if_instr_4, cnt4;
    logic        if_valid_4, fault4;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'h0050_0093 : {a[23:0], 8'h33};
    endfunction

    assign rdata  = imem_word(imem_addr);
    assign rdata4 = imem_word(imem_addr4);

    always #5 clock = ~clock;

    fetch_if_id_stage #(.IMEM_WORDS(256)) dut (
        .clock(clock), .reset(reset), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_target_i(target),
        .imem_addr_o(imem_addr), .imem_rdata_i(rdata),
        .if_id_pc_o(if_pc), .if_id_pc_plus4_o(if_pc4), .if_id_instr_o(if_instr),
        .if_id_valid_o(if_valid), .fetch_fault_o(fault), .fetch_count_o(cnt)
    );

    fetch_if_id_stage #(.IMEM_WORDS(4)) dut4 (
        .clock(clock), .reset(rst4), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_target_i(target),
        .imem_addr_o(imem_addr4), .imem_rdata_i(rdata4),
        .if_id_pc_o(if_pc_4), .if_id_pc_plus4_o(if_pc4_4), .if_id_instr_o(if_instr_4),
        .if_id_valid_o(if_valid_4), .fetch_fault_o(fault4), .fetch_count_o(cnt4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (if_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", if_instr, NOP); end
        total++; if (if_pc !== 32'h0 || if_pc4 !== 32'h0) begin bad++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", if_pc, if_pc4); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (cnt !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        tick();
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL boot got valid=%b addr=%h exp valid=0 addr=0", if_valid, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_pc4 !== 32'h4) begin bad++; $display("FAIL seq0 got v=%b pc=%h pc4=%h exp v=1 pc=0 pc4=4", if_valid, if_pc, if_pc4); end
        total++; if (if_instr !== 32'h0000_0033) begin bad++; $display("FAIL seq0_instr got=%h exp=%h", if_instr, 32'h0000_0033); end
        total++; if (imem_addr !== 32'h4 || cnt !== 32'd1) begin bad++; $display("FAIL seq0_addr got addr=%h cnt=%0d exp addr=4 cnt=1", imem_addr, cnt); end
        tick();
        total++; if (if_pc !== 32'h4 || imem_addr !== 32'h8 || cnt !== 32'd2) begin bad++; $display("FAIL seq1 got pc=%h addr=%h cnt=%0d exp pc=4 addr=8 cnt=2", if_pc, imem_addr, cnt); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (imem_addr !== 32'h8 || if_pc !== 32'h4 || if_valid !== 1'b1 || cnt !== 32'd2) begin
                bad++; $display("FAIL stall_hold%0d got addr=%h pc=%h v=%b cnt=%0d exp addr=8 pc=4 v=1 cnt=2", i, imem_addr, if_pc, if_valid, cnt);
            end
        end
        stall = 1'b0;
        tick();
        total++; if (if_pc !== 32'h8 || if_instr !== 32'h0050_0093 || imem_addr !== 32'hC || cnt !== 32'd3) begin
            bad++; $display("FAIL stall_release got pc=%h instr=%h addr=%h cnt=%0d exp pc=8 instr=00500093 addr=c cnt=3", if_pc, if_instr, imem_addr, cnt);
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        target   = 32'h40;
        stall    = 1'b1;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        total++; if (imem_addr !== 32'h40 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 || cnt !== 32'd3) begin
            bad++; $display("FAIL redir_bubble got addr=%h v=%b instr=%h pc=%h cnt=%0d exp addr=40 v=0 instr=%h pc=0 cnt=3", imem_addr, if_valid, if_instr, if_pc, cnt, NOP);
        end
        tick();
        total++; if (if_pc !== 32'h40 || if_pc4 !== 32'h44 || if_valid !== 1'b1 || if_instr !== 32'h0000_4033) begin
            bad++; $display("FAIL redir_target got pc=%h pc4=%h v=%b instr=%h exp pc=40 pc4=44 v=1 instr=00004033", if_pc, if_pc4, if_valid, if_instr);
        end
        total++; if (imem_addr !== 32'h44 || cnt !== 32'd4) begin bad++; $display("FAIL redir_next got addr=%h cnt=%0d exp addr=44 cnt=4", imem_addr, cnt); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        total++; if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 32'h48 || cnt !== 32'd4) begin
            bad++; $display("FAIL flush got v=%b instr=%h addr=%h cnt=%0d exp v=0 addr=48 cnt=4", if_valid, if_instr, imem_addr, cnt);
        end
        stall = 1'b1;
        tick();
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h48) begin bad++; $display("FAIL flush_stall got v=%b addr=%h exp v=0 addr=48", if_valid, imem_addr); end
        flush = 1'b0;
        stall = 1'b0;
        tick();
        total++; if (if_pc !== 32'h48 || if_valid !== 1'b1 || cnt !== 32'd5 || imem_addr !== 32'h4C) begin
            bad++; $display("FAIL flush_resume got pc=%h v=%b cnt=%0d addr=%h exp pc=48 v=1 cnt=5 addr=4c", if_pc, if_valid, cnt, imem_addr);
        end
    endtask

    task automatic test_fault();
        redirect = 1'b1;
        target   = 32'h42;
        tick();
        total++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h42) begin
            bad++; $display("FAIL misalign got fault=%b v=%b addr=%h exp fault=1 v=0 addr=42", fault, if_valid, imem_addr);
        end
        target = 32'h0;
        flush  = 1'b1;
        tick();
        tick();
        redirect = 1'b0;
        flush    = 1'b0;
        total++; if (fault !== 1'b1 || imem_addr !== 32'h42 || if_valid !== 1'b0 || cnt !== 32'd5) begin
            bad++; $display("FAIL fault_frozen got fault=%b addr=%h v=%b cnt=%0d exp fault=1 addr=42 v=0 cnt=5", fault, imem_addr, if_valid, cnt);
        end
    endtask

    task automatic test_range();
        rst4 = 1'b0;
        tick();
        tick();
        rst4 = 1'b1;
        tick();
        total++; if (if_valid_4 !== 1'b0 || imem_addr4 !== 32'h0) begin bad++; $display("FAIL range_boot got v=%b addr=%h exp v=0 addr=0", if_valid_4, imem_addr4); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (if_valid_4 !== 1'b1 || if_pc_4 !== 32'(4 * i) || cnt4 !== 32'(i + 1) || fault4 !== 1'b0) begin
                bad++; $display("FAIL range_seq%0d got v=%b pc=%h cnt=%0d fault=%b exp v=1 pc=%h cnt=%0d fault=0", i, if_valid_4, if_pc_4, cnt4, fault4, 32'(4 * i), i + 1);
            end
        end
        tick();
        total++; if (fault4 !== 1'b1 || if_valid_4 !== 1'b0 || cnt4 !== 32'd4 || imem_addr4 !== 32'h10) begin
            bad++; $display("FAIL range_fault got fault=%b v=%b cnt=%0d addr=%h exp fault=1 v=0 cnt=4 addr=10", fault4, if_valid_4, cnt4, imem_addr4);
        end
    endtask

    task automatic test_reset_recovery();
        stall = 1'b1;
        reset = 1'b0;
        tick();
        total++; if (fault !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_instr !== NOP || cnt !== 32'd0 || if_pc !== 32'h0 || if_pc4 !== 32'h0) begin
            bad++; $display("FAIL rst_from_fault got fault=%b addr=%h v=%b instr=%h cnt=%0d pc=%h exp all reset", fault, imem_addr, if_valid, if_instr, cnt, if_pc);
        end
        reset = 1'b1;
        tick();
        stall = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_boot got v=%b addr=%h exp v=0 addr=0", if_valid, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_pc4 !== 32'h4 || cnt !== 32'd1) begin
            bad++; $display("FAIL rst_restart got v=%b pc=%h pc4=%h cnt=%0d exp v=1 pc=0 pc4=4 cnt=1", if_valid, if_pc, if_pc4, cnt);
        end
        stall = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        total++; if (imem_addr !== 32'h0 || if_valid !== 1'b0 || cnt !== 32'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL rst_mid_stall got addr=%h v=%b cnt=%0d fault=%b exp addr=0 v=0 cnt=0 fault=0", imem_addr, if_valid, cnt, fault);
        end
        reset = 1'b1;
        stall = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_fault();
        test_range();
        test_reset_recovery();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
